// File: rtl/move_sequencer.sv
// move_sequencer
//
// Buffers 4-bit move codes from the solver in a circular FIFO and issues them
// one at a time to the move_to_step front-end. Each issued move is followed by
// a blanking window (move_done ignored), a bounded wait for move_done, and a
// mechanical settle delay before the next code is fetched. Code 15 (NULL)
// ends a sequence; codes 0, 1 and 14 are dropped and flagged.
//
// Ports
//   clock          in   system clock, rising edge
//   reset_n        in   synchronous active-low reset
//   move_in        in   [3:0] move code from solver
//   move_valid     in   move_in valid; write when move_valid & move_ready
//   move_ready     out  FIFO not full
//   go             in   pulse: start execution from IDLE
//   stop           in   pulse: graceful stop after the in-flight move
//   flush          in   pulse: empty FIFO and clear bad_code (IDLE/FAULT only)
//   clear_fault    in   pulse: FAULT -> IDLE
//   move_done      in   all steppers idle
//   next_move      out  [3:0] registered move code, reset 15
//   move_start     out  registered one-cycle start pulse
//   busy           out  not in IDLE or FAULT
//   seq_done       out  one-cycle pulse after a NULL is consumed
//   fault          out  move_done timeout occurred
//   bad_code       out  sticky: an invalid code was dropped
//   moves_executed out  [7:0] moves issued since last go (wraps)
//   fifo_count     out  [DEPTH_LOG2:0] FIFO occupancy
module move_sequencer #(
  parameter int unsigned DEPTH_LOG2     = 6,
  parameter int unsigned BLANK_CYCLES   = 1_500_000,
  parameter int unsigned SETTLE_CYCLES  = 5_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 100_000_000
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [3:0]            move_in,
  input  logic                  move_valid,
  output logic                  move_ready,
  input  logic                  go,
  input  logic                  stop,
  input  logic                  flush,
  input  logic                  clear_fault,
  input  logic                  move_done,
  output logic [3:0]            next_move,
  output logic                  move_start,
  output logic                  busy,
  output logic                  seq_done,
  output logic                  fault,
  output logic                  bad_code,
  output logic [7:0]            moves_executed,
  output logic [DEPTH_LOG2:0]   fifo_count
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;

  localparam logic [3:0]            CODE_NULL = 4'd15;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = 1;
  localparam logic [CW-1:0]         CNT_ONE   = 1;
  localparam logic [CW-1:0]         CNT_FULL  = CW'(DEPTH);
  localparam logic [31:0]           BLANK_LIM   = 32'(BLANK_CYCLES);
  localparam logic [31:0]           SETTLE_LIM  = 32'(SETTLE_CYCLES);
  localparam logic [31:0]           TIMEOUT_LIM = 32'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_BLANK,
    S_WAIT,
    S_SETTLE,
    S_FAULT
  } state_t;

  state_t                r_state;
  logic [3:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic [31:0]           r_cnt;
  logic                  r_stop_pend;
  logic [3:0]            r_next_move;
  logic                  r_move_start;
  logic                  r_busy;
  logic                  r_seq_done;
  logic                  r_fault;
  logic                  r_bad_code;
  logic [7:0]            r_moves;

  logic                  w_idle_like;
  logic                  w_busy_state;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_flush;
  logic                  w_wr;
  logic                  w_pop;
  logic [3:0]            w_head;
  logic                  w_head_bad;

  assign w_idle_like  = (r_state == S_IDLE) || (r_state == S_FAULT);
  assign w_busy_state = !w_idle_like;
  assign w_empty      = (r_count == '0);
  assign w_full       = (r_count == CNT_FULL);
  assign w_flush      = flush && w_idle_like;
  // A write coinciding with an honoured flush is discarded.
  assign w_wr         = move_valid && !w_full && !w_flush;
  // A pending stop takes priority over the head so a streaming FETCH can exit.
  assign w_pop        = (r_state == S_FETCH) && !r_stop_pend && !w_empty;
  assign w_head       = r_mem[r_rd_ptr];
  assign w_head_bad   = (w_head == 4'd0) || (w_head == 4'd1) || (w_head == 4'd14);

  assign move_ready     = !w_full;
  assign fifo_count     = r_count;
  assign next_move      = r_next_move;
  assign move_start     = r_move_start;
  assign busy           = r_busy;
  assign seq_done       = r_seq_done;
  assign fault          = r_fault;
  assign bad_code       = r_bad_code;
  assign moves_executed = r_moves;

  // FIFO storage (no reset needed; occupancy is tracked by r_count)
  always_ff @(posedge clock) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= move_in;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sequencer FSM with registered outputs
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_stop_pend  <= 1'b0;
      r_next_move  <= CODE_NULL;
      r_move_start <= 1'b0;
      r_busy       <= 1'b0;
      r_seq_done   <= 1'b0;
      r_fault      <= 1'b0;
      r_bad_code   <= 1'b0;
      r_moves      <= '0;
    end else begin
      r_move_start <= 1'b0;
      r_seq_done   <= 1'b0;

      if (w_busy_state && stop) begin
        r_stop_pend <= 1'b1;
      end
      if (w_flush) begin
        r_bad_code <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (go) begin
            r_state <= S_FETCH;
            r_busy  <= 1'b1;
            r_moves <= '0;
          end
        end

        S_FETCH: begin
          if (r_stop_pend) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_stop_pend <= 1'b0;
          end else if (!w_empty) begin
            if (w_head == CODE_NULL) begin
              r_state     <= S_IDLE;
              r_busy      <= 1'b0;
              r_seq_done  <= 1'b1;
              r_stop_pend <= 1'b0;
            end else if (w_head_bad) begin
              r_bad_code <= 1'b1;
            end else begin
              r_next_move <= w_head;
              r_state     <= S_ISSUE;
            end
          end
        end

        S_ISSUE: begin
          r_move_start <= 1'b1;
          r_moves      <= r_moves + 8'd1;
          r_cnt        <= '0;
          r_state      <= S_BLANK;
        end

        // Occupies BLANK_CYCLES+1 cycles, the first being the start pulse.
        S_BLANK: begin
          if (r_cnt == BLANK_LIM) begin
            r_cnt   <= 32'd1;
            r_state <= S_WAIT;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end

        // Counter runs 1..TIMEOUT; move_done wins over a simultaneous timeout.
        S_WAIT: begin
          if (move_done) begin
            r_cnt   <= 32'd1;
            r_state <= S_SETTLE;
          end else if (r_cnt == TIMEOUT_LIM) begin
            r_state <= S_FAULT;
            r_busy  <= 1'b0;
            r_fault <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end

        S_SETTLE: begin
          if (r_cnt == SETTLE_LIM) begin
            r_state <= S_FETCH;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end

        S_FAULT: begin
          if (clear_fault) begin
            r_state     <= S_IDLE;
            r_fault     <= 1'b0;
            r_stop_pend <= 1'b0;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_fault <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_move_sequencer.sv
`timescale 1ns/1ps
module tb_move_sequencer;

  localparam int B     = 4;
  localparam int S     = 8;
  localparam int T     = 50;
  localparam int DL2   = 6;
  localparam int DEPTH = 64;

  logic       clock;
  logic       reset_n;
  logic [3:0] move_in;
  logic       move_valid;
  logic       move_ready;
  logic       go;
  logic       stop;
  logic       flush;
  logic       clear_fault;
  logic       move_done;
  logic [3:0] next_move;
  logic       move_start;
  logic       busy;
  logic       seq_done;
  logic       fault;
  logic       bad_code;
  logic [7:0] moves_executed;
  logic [6:0] fifo_count;

  move_sequencer #(
    .DEPTH_LOG2     (DL2),
    .BLANK_CYCLES   (B),
    .SETTLE_CYCLES  (S),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .move_in        (move_in),
    .move_valid     (move_valid),
    .move_ready     (move_ready),
    .go             (go),
    .stop           (stop),
    .flush          (flush),
    .clear_fault    (clear_fault),
    .move_done      (move_done),
    .next_move      (next_move),
    .move_start     (move_start),
    .busy           (busy),
    .seq_done       (seq_done),
    .fault          (fault),
    .bad_code       (bad_code),
    .moves_executed (moves_executed),
    .fifo_count     (fifo_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Tracks the FIFO as a queue and each move as an absolute start edge;
  // blank/wait/settle windows are derived from that edge arithmetically.
  typedef enum int {M_IDLE, M_RUN, M_MOVE, M_SETTLE, M_FAULT} mmode_t;
  mmode_t     m_mode;
  int         m_cyc = 0;
  int         m_tstart;
  int         m_send;
  bit         m_sp;
  bit         m_ok = 0;
  logic [3:0] mq[$];
  logic [3:0] e_nm;
  bit         e_ms, e_busy, e_sd, e_fault, e_bad;
  logic [7:0] e_moves;

  task automatic model_step();
    bit         sp_old, was_busy, do_flush, do_wr;
    logic [3:0] v;
    m_cyc++;
    if (!reset_n) begin
      mq.delete();
      m_mode = M_IDLE; m_sp = 0;
      e_nm = 4'd15; e_ms = 0; e_busy = 0; e_sd = 0; e_fault = 0; e_bad = 0; e_moves = 8'd0;
      m_ok = 1;
      return;
    end
    e_ms = 0; e_sd = 0;
    sp_old   = m_sp;
    was_busy = (m_mode != M_IDLE) && (m_mode != M_FAULT);
    do_flush = flush && !was_busy;
    do_wr    = move_valid && (mq.size() != DEPTH) && !do_flush;
    if (stop && was_busy) m_sp = 1;
    case (m_mode)
      M_IDLE: if (go) begin m_mode = M_RUN; e_moves = 8'd0; end
      M_RUN: begin
        if (sp_old) m_mode = M_IDLE;
        else if (mq.size() > 0) begin
          v = mq.pop_front();
          if (v == 4'd15) begin e_sd = 1; m_mode = M_IDLE; end
          else if (v == 4'd0 || v == 4'd1 || v == 4'd14) e_bad = 1;
          else begin e_nm = v; m_mode = M_MOVE; m_tstart = m_cyc + 1; end
        end
      end
      M_MOVE: begin
        if (m_cyc == m_tstart) begin e_ms = 1; e_moves = e_moves + 8'd1; end
        else if (m_cyc >= m_tstart + B + 2 && move_done) begin m_mode = M_SETTLE; m_send = m_cyc + S; end
        else if (m_cyc == m_tstart + B + T + 1) m_mode = M_FAULT;
      end
      M_SETTLE: if (m_cyc == m_send) m_mode = M_RUN;
      M_FAULT:  if (clear_fault) m_mode = M_IDLE;
      default:  m_mode = M_IDLE;
    endcase
    if (m_mode == M_IDLE) m_sp = 0;
    if (do_flush) begin mq.delete(); e_bad = 0; end
    if (do_wr) mq.push_back(move_in);
    e_busy  = (m_mode != M_IDLE) && (m_mode != M_FAULT);
    e_fault = (m_mode == M_FAULT);
  endtask

  initial begin
    forever begin
      @(posedge clock);
      model_step();
    end
  end

  // ---------------- compare + monitor (after each edge) ----------------
  int         ncyc = 0;
  int         starts = 0;
  int         seqs = 0;
  int         first_start = 0;
  int         last_start = 0;
  int         prev_start = 0;
  int         fault_at = 0;
  bit         fault_q = 0;
  logic [3:0] nm_q[$];

  initial begin
    logic [24:0] exp_v, act_v;
    forever begin
      @(posedge clock);
      #1;
      ncyc++;
      if (m_ok) begin
        exp_v = {e_nm, e_ms, e_busy, e_sd, e_fault, e_bad, e_moves, 7'(mq.size()), (mq.size() != DEPTH)};
        act_v = {next_move, move_start, busy, seq_done, fault, bad_code, moves_executed, fifo_count, move_ready};
        n_tests++;
        if (exp_v !== act_v) begin
          n_fail++;
          $display("FAIL cycle %0d outputs {nm,ms,busy,sd,fault,bad,moves,cnt,rdy}: got %h, expected %h",
                   ncyc, act_v, exp_v);
        end
      end
      if (move_start === 1'b1) begin
        starts++;
        if (starts == 1) first_start = ncyc;
        prev_start = last_start;
        last_start = ncyc;
        nm_q.push_back(next_move);
      end
      if (seq_done === 1'b1) seqs++;
      if (fault === 1'b1 && !fault_q) fault_at = ncyc;
      fault_q = (fault === 1'b1);
    end
  end

  // ---------------- stepper model driving move_done ----------------
  bit st_stuck = 0;
  bit st_rand  = 0;
  int st_delay = 20;

  initial begin
    int cnt;
    int d;
    cnt = 0;
    move_done = 1'b1;
    forever begin
      @(negedge clock);
      if (st_stuck) move_done = 1'b0;
      else if (move_start === 1'b1) begin
        d = st_rand ? int'($urandom_range(0, 60)) : st_delay;
        if (d == 0) move_done = 1'b1;
        else begin move_done = 1'b0; cnt = d; end
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) move_done = 1'b1;
      end else move_done = 1'b1;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clock);
  endtask

  task automatic push(input logic [3:0] c);
    move_in = c; move_valid = 1'b1;
    tick();
    move_valid = 1'b0;
  endtask

  task automatic pulse_go();    go = 1'b1;          tick(); go = 1'b0;          endtask
  task automatic pulse_stop();  stop = 1'b1;        tick(); stop = 1'b0;        endtask
  task automatic pulse_flush(); flush = 1'b1;       tick(); flush = 1'b0;       endtask
  task automatic pulse_clear(); clear_fault = 1'b1; tick(); clear_fault = 1'b0; endtask

  task automatic clear_stats();
    starts = 0; seqs = 0; first_start = 0; last_start = 0; prev_start = 0; fault_at = 0;
    nm_q.delete();
  endtask

  task automatic wait_idle(input string name, input int maxc);
    for (int i = 0; i < maxc && busy; i++) tick();
    check({name, " reaches idle"}, int'(busy), 0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " next_move"},      int'(next_move), 15);
    check({tag, " move_start"},     int'(move_start), 0);
    check({tag, " busy"},           int'(busy), 0);
    check({tag, " seq_done"},       int'(seq_done), 0);
    check({tag, " fault"},          int'(fault), 0);
    check({tag, " bad_code"},       int'(bad_code), 0);
    check({tag, " moves_executed"}, int'(moves_executed), 0);
    check({tag, " fifo_count"},     int'(fifo_count), 0);
    check({tag, " move_ready"},     int'(move_ready), 1);
  endtask

  // ---------------- directed + random sequence ----------------
  logic [3:0] exp_seq[$];
  int         go_edge;
  int         errs;
  logic [3:0] c;

  initial begin
    reset_n = 1'b0; move_in = 4'd0; move_valid = 1'b0;
    go = 1'b0; stop = 1'b0; flush = 1'b0; clear_fault = 1'b0;
    tick(); tick();
    check_reset_values("reset");
    reset_n = 1'b1;
    tick();

    // 1: two moves then NULL
    st_delay = 20;
    clear_stats();
    push(4'd2); push(4'd5); push(4'd15);
    go = 1'b1; tick(); go = 1'b0;
    go_edge = ncyc;
    wait_idle("t1", 300);
    check("t1 starts", starts, 2);
    check("t1 go-to-start edges", first_start - go_edge, 2);
    check("t1 nm0", (nm_q.size() > 0) ? int'(nm_q[0]) : -1, 2);
    check("t1 nm1", (nm_q.size() > 1) ? int'(nm_q[1]) : -1, 5);
    check("t1 moves_executed", int'(moves_executed), 2);
    check("t1 seq_done count", seqs, 1);
    check("t1 start spacing", last_start - prev_start, 31);

    // 2: fill FIFO across pointer wrap, overflow write dropped, order kept
    st_delay = 0;
    clear_stats();
    exp_seq.delete();
    for (int i = 0; i < 63; i++) begin
      c = 4'($urandom_range(2, 13));
      exp_seq.push_back(c);
      push(c);
    end
    push(4'd15);
    check("t2 full ready", int'(move_ready), 0);
    check("t2 full count", int'(fifo_count), 64);
    push(4'd7);
    check("t2 overflow count", int'(fifo_count), 64);
    pulse_go();
    wait_idle("t2", 3000);
    check("t2 starts", starts, 63);
    errs = 0;
    for (int i = 0; i < 63; i++)
      if (i >= nm_q.size() || nm_q[i] !== exp_seq[i]) errs++;
    check("t2 order errors", errs, 0);
    check("t2 seq_done count", seqs, 1);
    check("t2 drained", int'(fifo_count), 0);

    // 3: invalid codes dropped
    st_delay = 20;
    clear_stats();
    push(4'd0); push(4'd14); push(4'd6); push(4'd15);
    pulse_go();
    wait_idle("t3", 300);
    check("t3 bad_code", int'(bad_code), 1);
    check("t3 starts", starts, 1);
    check("t3 nm0", (nm_q.size() > 0) ? int'(nm_q[0]) : -1, 6);

    // 4: timeout fault
    st_stuck = 1;
    clear_stats();
    push(4'd3); push(4'd9); push(4'd15);
    pulse_go();
    for (int i = 0; i < 300 && !fault; i++) tick();
    check("t4 fault", int'(fault), 1);
    check("t4 fault delay", fault_at - first_start, B + T + 1);
    check("t4 fifo kept", int'(fifo_count), 2);
    pulse_go(); tick(); tick();
    check("t4 go ignored busy", int'(busy), 0);
    check("t4 go ignored fault", int'(fault), 1);
    check("t4 go ignored starts", starts, 1);
    pulse_clear();
    check("t4 cleared fault", int'(fault), 0);
    check("t4 cleared busy", int'(busy), 0);
    check("t4 cleared fifo kept", int'(fifo_count), 2);
    st_stuck = 0;
    pulse_flush();
    check("t4 flush count", int'(fifo_count), 0);
    check("t4 flush bad_code", int'(bad_code), 0);

    // 5: graceful stop during blanking
    clear_stats();
    push(4'd2); push(4'd3); push(4'd4);
    pulse_go();
    for (int i = 0; i < 20 && starts == 0; i++) tick();
    tick();
    pulse_stop();
    wait_idle("t5", 200);
    check("t5 starts", starts, 1);
    check("t5 idle edge after start", ncyc - first_start, 30);
    check("t5 fifo left", int'(fifo_count), 2);
    check("t5 moves_executed", int'(moves_executed), 1);
    pulse_flush();

    // 6: reset during WAIT
    clear_stats();
    push(4'd5); push(4'd15);
    pulse_go();
    for (int i = 0; i < 20 && starts == 0; i++) tick();
    for (int i = 0; i < 8; i++) tick();
    reset_n = 1'b0;
    tick();
    check_reset_values("t6 midmove reset");
    reset_n = 1'b1;
    tick();
    pulse_go();
    for (int i = 0; i < 10; i++) tick();
    check("t6 no new start", starts, 1);
    check("t6 streaming busy", int'(busy), 1);
    check("t6 fifo empty", int'(fifo_count), 0);
    pulse_stop(); tick();
    check("t6 stop to idle", int'(busy), 0);

    // 7: randomized traffic checked cycle by cycle against the model
    st_rand = 1;
    for (int k = 0; k < 3000; k++) begin
      move_valid  = ($urandom_range(0, 9) < 3);
      move_in     = 4'($urandom_range(0, 15));
      go          = ($urandom_range(0, 19) == 0);
      stop        = ($urandom_range(0, 49) == 0);
      flush       = ($urandom_range(0, 49) == 0);
      clear_fault = ($urandom_range(0, 19) == 0);
      reset_n     = ($urandom_range(0, 499) != 0);
      tick();
    end
    move_valid = 1'b0; go = 1'b0; stop = 1'b0; flush = 1'b0; clear_fault = 1'b0; reset_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/move_sequencer.md
# move_sequencer

Move sequencer between the solver and the `move_to_step` stepper front-end. It buffers a stream of 4-bit move codes in a FIFO and issues them one at a time as `next_move` plus a one-cycle `move_start`. After each start it blanks the done signal, waits for completion (with a timeout), then applies a mechanical settle delay before the next move. A NULL code (4'd15) ends a sequence.

## Interface
- `DEPTH_LOG2`, 6: FIFO holds 2^DEPTH_LOG2 move codes.
- `BLANK_CYCLES`, 1_500_000: cycles after `move_start` during which `move_done` is ignored (15 ms at 100 MHz).
- `SETTLE_CYCLES`, 5_000_000: idle cycles between completion of one move and start of the next.
- `TIMEOUT_CYCLES`, 100_000_000: maximum wait for `move_done` after blanking; exceeding it raises a fault.
- `clock`  in  1: system clock; all logic on rising edge.
- `reset_n`  in  1: synchronous, active-low reset.
- `move_in`  in  4: move code from solver.
- `move_valid`  in  1: `move_in` is valid.
- `move_ready`  out  1: FIFO can accept; a write occurs when `move_valid & move_ready`.
- `go`  in  1: pulse; starts execution from IDLE.
- `stop`  in  1: pulse; requests a graceful stop after the current move.
- `flush`  in  1: pulse; empties the FIFO. Honoured only in IDLE or FAULT.
- `clear_fault`  in  1: pulse; FAULT -> IDLE.
- `move_done`  in  1: from `move_to_step`; high when all steppers are idle.
- `next_move`  out  4: registered move code to `move_to_step`.
- `move_start`  out  1: registered one-cycle start pulse.
- `busy`  out  1: high in any state other than IDLE and FAULT.
- `seq_done`  out  1: one-cycle pulse when a NULL is consumed.
- `fault`  out  1: high in FAULT.
- `bad_code`  out  1: sticky; set when an invalid code (0, 1 or 14) is dropped. Cleared by reset or `flush`.
- `moves_executed`  out  8: count of moves issued since the last `go`; wraps at 255 -> 0.
- `fifo_count`  out  DEPTH_LOG2+1: current occupancy.

## Operation
- FIFO: circular buffer with DEPTH_LOG2-bit pointers and a DEPTH_LOG2+1-bit count.
  - `move_ready = (fifo_count != 2^DEPTH_LOG2)`.
  - A simultaneous write and read leaves the count unchanged.
  - Pointers wrap modulo the depth.
  - `flush` zeroes both pointers and the count. A write presented in the same cycle as `flush` is discarded.
- States and transitions:
  - IDLE: wait for `go`. `go` -> FETCH and clears `moves_executed`.
  - FETCH:
    - FIFO empty: stay in FETCH (streaming).
    - `stop` pending: -> IDLE.
    - Otherwise pop the head:
      - 15 (NULL): pulse `seq_done`, -> IDLE.
      - 0, 1 or 14: set `bad_code`, stay in FETCH.
      - 2-13: latch into `next_move`, -> ISSUE.
  - ISSUE: assert `move_start` for exactly one cycle, increment `moves_executed`, load the blank counter, -> BLANK.
  - BLANK: count BLANK_CYCLES, ignoring `move_done`, then load the timeout counter, -> WAIT.
  - WAIT:
    - `move_done == 1`: -> SETTLE.
    - Timeout counter reaches TIMEOUT_CYCLES: -> FAULT.
  - SETTLE: count SETTLE_CYCLES, -> FETCH.
  - FAULT: hold all outputs, ignore `go`. `clear_fault` -> IDLE. FIFO contents are kept.
- `stop`:
  - Sets a pending flag from any busy state. The in-flight move always runs to completion, because aborting mid-turn misaligns the cube.
  - The flag is sampled in FETCH. It is cleared on entry to IDLE.
  - `stop` in IDLE is ignored.
- `next_move`:
  - Held constant from ISSUE until the next FETCH pop, because `dir_pin` derives from it combinationally.
  - Reset value 4'd15, so no stepper start can decode from it.
- `go` while busy is ignored. `flush` while busy is ignored.
- Counters are 32-bit and compare with equality only.

## Timing
- Reset values: `next_move` = 15, `move_start` = 0, `busy` = 0, `seq_done` = 0, `fault` = 0, `bad_code` = 0, `moves_executed` = 0, `fifo_count` = 0, `move_ready` = 1. State = IDLE, FIFO empty, stop flag clear.
- Reset asserted mid-move returns to IDLE on the next edge. It drops any pending `move_start`; the stepper is not notified.
- Latency from `go` (FIFO non-empty, valid head) to `move_start` high: 3 edges (`go` -> FETCH -> ISSUE, pulse registered on exit from ISSUE).
- `move_start` is high for 1 cycle. `next_move` is stable at least 1 cycle before and throughout the pulse.
- Minimum spacing between consecutive `move_start` pulses: BLANK_CYCLES + 1 + SETTLE_CYCLES + 3.
- A FIFO write is visible to FETCH on the cycle after the write.
- `seq_done` is high on the cycle after the NULL pop; `busy` is low on the same cycle.

## Test plan
- Reset, then push R, Ui, NULL, then `go` with BLANK=4, SETTLE=8, TIMEOUT=50, and a model that drops `move_done` for 20 cycles after each start -> two `move_start` pulses with `next_move` = 2 then 5, `moves_executed` = 2, a single `seq_done`, `busy` = 0.
- Fill the FIFO with 64 writes while idle -> `move_ready` = 0 and the 65th write is dropped. Run to NULL -> order preserved across the pointer wrap.
- Push codes 0, 14, F, NULL -> `bad_code` = 1, exactly one `move_start` with `next_move` = 6.
- Hold `move_done` = 0 forever after a start -> `fault` = 1 exactly BLANK+TIMEOUT+1 cycles after the pulse. `go` is ignored; `clear_fault` -> IDLE with FIFO contents intact.
- Pulse `stop` during BLANK of move 1 of 3 -> move 1 completes through SETTLE, then IDLE, with no second `move_start` and 2 moves left in the FIFO.
- Drop `reset_n` for 1 cycle during WAIT -> all outputs at reset values on the next cycle. `go` afterwards does nothing until new moves are pushed.
